flagreg_stack: RTL and testbench

Parametrised condition-flag register with an interrupt save/restore stack. Every cycle it derives Zero and Negative from the ALU result and takes Carry and Overflow from the ALU. Each flag is written only when its enable bit is set. A LIFO of DEPTH entries saves and restores the flag set across interrupt or subroutine boundaries. It sits between the ALU output and the branch-condition logic, replacing the fixed 16-bit always-load flag register.

---
 rtl/flagreg_stack.sv | 86 ++++++++
 tb/tb_flagreg_stack.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flagreg_stack.sv
// flagreg_stack: enable-masked condition-flag register {V,C,N,Z} with a
// LIFO save/restore stack and sticky overflow/underflow error bits.
`default_nettype none

module flagreg_stack #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] aluout,
    input  logic                  carry_in,
    input  logic                  ovf_in,
    input  logic [3:0]            flag_we,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  err_clr,
    output logic [3:0]            flags,
    output logic [CW-1:0]         depth,
    output logic                  empty,
    output logic                  full,
    output logic                  err_ovf,
    output logic                  err_unf
);

    // Address width of the stack array; the array is rounded up to a power of
    // two so the pointer slice indexes it without a range mismatch.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]    stack_mem [0:(2**AW)-1];
    logic [3:0]    candidate;
    logic [3:0]    updated;
    logic          do_push;
    logic          do_pop;
    logic          ovf_evt;
    logic          unf_evt;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    always_comb begin
        candidate = {ovf_in, carry_in, aluout[DATA_WIDTH-1], (aluout == '0)};
        updated   = (flag_we & candidate) | (~flag_we & flags);
        do_push   = push & ~pop & ~full;
        do_pop    = pop & ~push & ~empty;
        ovf_evt   = push & ~pop & full;
        unf_evt   = pop & ~push & empty;
        wr_idx    = AW'(depth);
        rd_idx    = AW'(depth - CW'(1));
    end

    assign empty = (depth == '0);
    assign full  = (depth == CW'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags   <= 4'b0000;
            depth   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            // A successful pop restores the saved set and overrides flag_we.
            if (do_pop) begin
                flags <= stack_mem[rd_idx];
                depth <= depth - CW'(1);
            end else begin
                flags <= updated;
                if (do_push) begin
                    depth <= depth + CW'(1);
                end
            end
            err_ovf <= ovf_evt | (err_ovf & ~err_clr);
            err_unf <= unf_evt | (err_unf & ~err_clr);
        end
    end

    // Entries carry no reset: they are only ever read below the pointer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[wr_idx] <= flags;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_flagreg_stack.sv
// Directed self-checking bench for flagreg_stack, including two extra
// parameterisations (8-bit/DEPTH 1 and 32-bit/DEPTH 7) sharing the controls.
`default_nettype none

module tb_flagreg_stack;

    logic        clk;
    logic        reset;
    logic [15:0] aluout;
    logic [7:0]  aluout8;
    logic [31:0] aluout32;
    logic        carry_in;
    logic        ovf_in;
    logic [3:0]  flag_we;
    logic        push;
    logic        pop;
    logic        err_clr;

    logic [3:0]  flags,   flags8,   flags32;
    logic [2:0]  depth,             depth32;
    logic [0:0]  depth8;
    logic        empty,   empty8,   empty32;
    logic        full,    full8,    full32;
    logic        err_ovf, err_ovf8, err_ovf32;
    logic        err_unf, err_unf8, err_unf32;

    int passed = 0;
    int total  = 0;

    flagreg_stack #(.DATA_WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .aluout(aluout), .carry_in(carry_in),
        .ovf_in(ovf_in), .flag_we(flag_we), .push(push), .pop(pop),
        .err_clr(err_clr), .flags(flags), .depth(depth), .empty(empty),
        .full(full), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    flagreg_stack #(.DATA_WIDTH(8), .DEPTH(1)) dut8 (
        .clk(clk), .reset(reset), .aluout(aluout8), .carry_in(carry_in),
        .ovf_in(ovf_in), .flag_we(flag_we), .push(push), .pop(pop),
        .err_clr(err_clr), .flags(flags8), .depth(depth8), .empty(empty8),
        .full(full8), .err_ovf(err_ovf8), .err_unf(err_unf8)
    );

    flagreg_stack #(.DATA_WIDTH(32), .DEPTH(7)) dut32 (
        .clk(clk), .reset(reset), .aluout(aluout32), .carry_in(carry_in),
        .ovf_in(ovf_in), .flag_we(flag_we), .push(push), .pop(pop),
        .err_clr(err_clr), .flags(flags32), .depth(depth32), .empty(empty32),
        .full(full32), .err_ovf(err_ovf32), .err_unf(err_unf32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 0; pop = 0; err_clr = 0; flag_we = 4'b0000;
    endtask

    task automatic test_reset();
        reset = 0; aluout = 0; aluout8 = 0; aluout32 = 0;
        carry_in = 0; ovf_in = 0; idle();
        step();
        total++;
        if ({flags, depth, empty, full, err_ovf, err_unf} !== {4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_state: flags=%b depth=%0d empty=%b full=%b ovf=%b unf=%b",
                     flags, depth, empty, full, err_ovf, err_unf);
        else passed++;
        reset = 1;
        step();
        // Mid-run reset with two entries on the stack must clear immediately.
        push = 1; step(); step(); idle();
        total++;
        if (depth !== 3'd2) $display("FAIL pre_reset_depth: got %0d want 2", depth);
        else passed++;
        flag_we = 4'b1111; aluout = 0; carry_in = 1; step(); idle();
        #2 reset = 0; #1;
        total++;
        if ({flags, depth, empty} !== {4'b0000, 3'd0, 1'b1})
            $display("FAIL async_reset: flags=%b depth=%0d empty=%b want 0000/0/1", flags, depth, empty);
        else passed++;
        step();
        reset = 1;
    endtask

    task automatic test_flag_update();
        aluout = 16'h0000; carry_in = 1; ovf_in = 0; flag_we = 4'b1111;
        step();
        total++;
        if (flags !== 4'b0101) $display("FAIL flag_update: got %b want 0101", flags);
        else passed++;
    endtask

    task automatic test_masked();
        aluout = 16'h8000; carry_in = 0; ovf_in = 1; flag_we = 4'b0010;
        step();
        total++;
        if (flags !== 4'b0111) $display("FAIL masked_update: got %b want 0111", flags);
        else passed++;
    endtask

    task automatic test_push_restore();
        aluout = 16'h8000; carry_in = 0; ovf_in = 1; flag_we = 4'b1111;
        step();
        total++;
        if (flags !== 4'b1010) $display("FAIL setup_1010: got %b want 1010", flags);
        else passed++;
        aluout = 0; carry_in = 0; ovf_in = 0; push = 1;
        step();
        total++;
        if ({flags, depth} !== {4'b0001, 3'd1})
            $display("FAIL push_update: flags=%b depth=%0d want 0001/1", flags, depth);
        else passed++;
        push = 0; pop = 1;
        step();
        total++;
        if ({flags, depth, empty} !== {4'b1010, 3'd0, 1'b1})
            $display("FAIL pop_restore: flags=%b depth=%0d empty=%b want 1010/0/1", flags, depth, empty);
        else passed++;
        idle();
    endtask

    task automatic test_ovf_unf();
        idle(); push = 1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 4) begin
                total++;
                if ({depth, full, err_ovf} !== {3'd4, 1'b1, 1'b0})
                    $display("FAIL fill_4: depth=%0d full=%b ovf=%b want 4/1/0", depth, full, err_ovf);
                else passed++;
            end
        end
        total++;
        if ({depth, full, err_ovf} !== {3'd4, 1'b1, 1'b1})
            $display("FAIL overflow: depth=%0d full=%b ovf=%b want 4/1/1", depth, full, err_ovf);
        else passed++;
        push = 0; pop = 1;
        for (int i = 1; i <= 5; i++) step();
        total++;
        if ({depth, empty, err_unf, err_ovf, flags} !== {3'd0, 1'b1, 1'b1, 1'b1, 4'b1010})
            $display("FAIL underflow: depth=%0d empty=%b unf=%b ovf=%b flags=%b want 0/1/1/1/1010",
                     depth, empty, err_unf, err_ovf, flags);
        else passed++;
        pop = 0; err_clr = 1;
        step();
        total++;
        if ({err_ovf, err_unf} !== 2'b00)
            $display("FAIL err_clr: ovf=%b unf=%b want 0/0", err_ovf, err_unf);
        else passed++;
        idle();
    endtask

    task automatic test_simultaneous();
        push = 1; step(); step();
        aluout = 16'h0001; carry_in = 1; ovf_in = 1; flag_we = 4'b1111; pop = 1;
        step();
        total++;
        if ({depth, flags, err_ovf, err_unf} !== {3'd2, 4'b1100, 1'b0, 1'b0})
            $display("FAIL push_pop_same: depth=%0d flags=%b ovf=%b unf=%b want 2/1100/0/0",
                     depth, flags, err_ovf, err_unf);
        else passed++;
        idle(); push = 1; step(); step();
        err_clr = 1;
        step();
        total++;
        if ({depth, err_ovf} !== {3'd4, 1'b1})
            $display("FAIL clr_vs_set: depth=%0d ovf=%b want 4/1", depth, err_ovf);
        else passed++;
        idle();
    endtask

    task automatic test_back_to_back();
        reset = 0; #1; reset = 1; idle();
        flag_we = 4'b1111; aluout = 0; carry_in = 0; ovf_in = 0;
        step();
        push = 1; aluout = 16'h8000; carry_in = 1; ovf_in = 0; step();
        aluout = 16'h0001; carry_in = 0; ovf_in = 1; step();
        aluout = 16'h0000; carry_in = 1; ovf_in = 1; step();
        total++;
        if ({flags, depth} !== {4'b1101, 3'd3})
            $display("FAIL b2b_push: flags=%b depth=%0d want 1101/3", flags, depth);
        else passed++;
        push = 0; pop = 1;
        step();
        total++;
        if (flags !== 4'b1000) $display("FAIL b2b_pop1: got %b want 1000", flags);
        else passed++;
        step();
        total++;
        if (flags !== 4'b0110) $display("FAIL b2b_pop2: got %b want 0110", flags);
        else passed++;
        step();
        total++;
        if ({flags, depth, err_unf} !== {4'b0001, 3'd0, 1'b0})
            $display("FAIL b2b_pop3: flags=%b depth=%0d unf=%b want 0001/0/0", flags, depth, err_unf);
        else passed++;
        idle();
    endtask

    task automatic test_params();
        reset = 0; #1; reset = 1; idle();
        flag_we = 4'b1111; carry_in = 0; ovf_in = 0;
        aluout8 = 8'h80; aluout32 = 32'h8000_0000;
        step();
        total++;
        if ({flags8, flags32} !== {4'b0010, 4'b0010})
            $display("FAIL param_msb: w8=%b w32=%b want 0010/0010", flags8, flags32);
        else passed++;
        aluout8 = 8'h7F; aluout32 = 32'h0000_8000;
        step();
        total++;
        if ({flags8, flags32} !== {4'b0000, 4'b0000})
            $display("FAIL param_non_msb: w8=%b w32=%b want 0000/0000", flags8, flags32);
        else passed++;
        aluout8 = 8'h00; aluout32 = 32'h0;
        step();
        total++;
        if ({flags8, flags32} !== {4'b0001, 4'b0001})
            $display("FAIL param_zero: w8=%b w32=%b want 0001/0001", flags8, flags32);
        else passed++;
        idle(); push = 1;
        step();
        total++;
        if ({depth8, full8, full32} !== {1'b1, 1'b1, 1'b0})
            $display("FAIL param_d1_full: depth8=%0d full8=%b full32=%b want 1/1/0", depth8, full8, full32);
        else passed++;
        for (int i = 0; i < 6; i++) step();
        total++;
        if ({depth32, full32, err_ovf32, err_ovf8} !== {3'd7, 1'b1, 1'b0, 1'b1})
            $display("FAIL param_d7_full: depth32=%0d full32=%b ovf32=%b ovf8=%b want 7/1/0/1",
                     depth32, full32, err_ovf32, err_ovf8);
        else passed++;
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_flag_update();
        test_masked();
        test_push_restore();
        test_ovf_unf();
        test_simultaneous();
        test_back_to_back();
        test_params();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
